// File: rtl/rr_grant_encoder_4.sv
// Four-requester round-robin arbiter driving the {a,b} select of a 2-to-4 decoder.
// Ports: clk, rst_n (async low), req[3:0], done -> a, b, grant_valid, timeout.
module rr_grant_encoder_4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic       a,
    output logic       b,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD = 8'(HOLD_MAX);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic       gv_q, gv_d;
    logic       to_q, to_d;

    logic [1:0] pick;
    logic [1:0] probe;
    logic       found;

    // Scan from the slot after the last grantee, wrapping; the 2-bit
    // add wraps naturally and k=4 lands back on the last grantee.
    always_comb begin
        pick  = '0;
        probe = '0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            probe = last_q + 2'(k);
            if (!found && req[probe]) begin
                pick  = probe;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gv_d    = gv_q;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                gv_d = 1'b0;
                if (found) begin
                    idx_d   = pick;
                    gv_d    = 1'b1;
                    cnt_d   = 8'd1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                cnt_d = cnt_q + 8'd1;
                // done and withdraw outrank the timer, so a collision
                // with the last hold cycle never pulses timeout.
                if (done || !req[idx_q] || cnt_q == HOLD) begin
                    to_d    = !done && req[idx_q];
                    gv_d    = 1'b0;
                    last_d  = idx_q;
                    cnt_d   = 8'd0;
                    state_d = GAP;
                end
            end
            GAP: begin
                gv_d    = 1'b0;
                state_d = IDLE;
            end
            default: begin
                gv_d    = 1'b0;
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= 8'd0;
            gv_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gv_q    <= gv_d;
            to_q    <= to_d;
        end
    end

    assign a           = idx_q[1];
    assign b           = idx_q[0];
    assign grant_valid = gv_q;
    assign timeout     = to_q;

endmodule
